// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared scheduler state encoding and sizing helper.
package sys_array_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_MASK, S_WAIT, S_DONE, S_ERR} sched_state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any
);
  int   j;
  logic found;
  always_comb begin
    gnt_onehot = '0;
    gnt_idx = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j[W-1:0]]) begin
        found = 1'b1;
        gnt_idx = j[W-1:0];
        gnt_onehot[j[W-1:0]] = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/sys_array_scheduler.sv
// sys_array_scheduler: round-robin sharing of one fetcher, with weight-reuse tracking and WAIT timeout.
module sys_array_scheduler
  import sys_array_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int READY_MASK = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               reuse_w,
  output logic [N_REQ-1:0]               grant,
  output logic [clog2_min1(N_REQ)-1:0]   sel,
  output logic [N_REQ-1:0]               done,
  output logic [N_REQ-1:0]               err,
  output logic                           busy,
  output logic                           fa_weights_load,
  output logic                           fa_start_comp,
  input  logic                           fa_ready
);
  localparam int SW = clog2_min1(N_REQ);
  localparam int CW = $clog2(TIMEOUT + READY_MASK + 1);
  sched_state_t     r_state, w_next;
  logic [N_REQ-1:0] r_grant, w_gnt;
  logic [SW-1:0]    r_sel, r_ptr, r_owner, w_idx;
  logic             r_wvalid, w_any, w_reuse, w_mask_end, w_tmo;
  logic [CW-1:0]    r_cnt;
  rr_arbiter #(.N(N_REQ), .W(SW)) u_arb (
    .req        (req),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt),
    .gnt_idx    (w_idx),
    .any        (w_any)
  );
  assign w_reuse    = reuse_w[w_idx] && r_wvalid && (r_owner == w_idx);
  assign w_mask_end = r_cnt == CW'(READY_MASK - 1);
  assign w_tmo      = r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? (w_reuse ? S_START : S_LOAD) : S_IDLE;
      S_LOAD:  w_next = S_START;
      S_START: w_next = (READY_MASK == 0) ? S_WAIT : S_MASK;
      S_MASK:  w_next = w_mask_end ? S_WAIT : S_MASK;
      S_WAIT:  w_next = fa_ready ? S_DONE : (w_tmo ? S_ERR : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  // r_cnt is shared: counts the mask window, then restarts for the WAIT timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_sel    <= '0;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_wvalid <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_gnt;
        r_sel   <= w_idx;
        r_ptr   <= (w_idx == SW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == S_DONE || r_state == S_ERR) r_grant <= '0;
      if (r_state == S_LOAD) begin
        r_owner  <= r_sel;
        r_wvalid <= 1'b1;
      end
      if (r_state == S_ERR) r_wvalid <= 1'b0;
      r_cnt <= (r_state == S_START || (r_state == S_MASK && w_mask_end)) ? '0 : r_cnt + 1'b1;
    end
  end
  assign grant           = r_grant;
  assign sel             = r_sel;
  assign done            = (r_state == S_DONE) ? r_grant : '0;
  assign err             = (r_state == S_ERR) ? r_grant : '0;
  assign busy            = r_state != S_IDLE;
  assign fa_weights_load = r_state == S_LOAD;
  assign fa_start_comp   = r_state == S_START;
endmodule

// File: tb/tb_sys_array_scheduler.sv
// tb_sys_array_scheduler: job-level reference model with a simple fetcher ready model.
module tb_sys_array_scheduler;
  import sys_array_pkg::*;
  localparam int N  = 3;
  localparam int RM = 2;
  localparam int TO = 16;
  localparam int SW = clog2_min1(N);
  logic          clk = 0, reset = 1;
  logic [N-1:0]  req = '0, reuse_w = '0, grant, done, err;
  logic [SW-1:0] sel;
  logic          busy, fa_weights_load, fa_start_comp, fa_ready;
  int cyc = 0, s_cyc = -100, d_ready = 3;
  bit never = 0;
  int errors = 0, checks = 0;
  int m_ptr = 0, m_owner = 0;
  bit m_valid = 0;
  sys_array_scheduler #(.N_REQ(N), .READY_MASK(RM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .reuse_w(reuse_w), .grant(grant), .sel(sel),
    .done(done), .err(err), .busy(busy), .fa_weights_load(fa_weights_load),
    .fa_start_comp(fa_start_comp), .fa_ready(fa_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fa_start_comp) s_cyc <= cyc;
  end
  // ready stays stale-high for one cycle after start, then rises d_ready cycles after start
  assign fa_ready = (cyc - s_cyc <= 1) || (!never && (cyc - s_cyc >= d_ready));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done_err"}, int'(done | err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fa"}, int'({fa_weights_load, fa_start_comp}), 0);
  endtask
  task automatic run_job(input logic [N-1:0] rq, input logic [N-1:0] ru, input int d, input bit nr);
    int w, g, loads, load_c, start_c, end_c, es, ee;
    logic [N-1:0] end_v;
    bit end_err, rl;
    w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
    rl = !(ru[w] && m_valid && m_owner == w);
    req = rq; reuse_w = ru; d_ready = d; never = nr;
    g = -1; loads = 0; load_c = -1; start_c = -1; end_c = -1; end_v = '0; end_err = 0;
    for (int k = 0; k < 80 && end_c < 0; k++) begin
      @(negedge clk);
      chk("grant_onehot0", int'($onehot0(grant)), 1);
      chk("load_start_excl", int'(fa_weights_load && fa_start_comp), 0);
      if (g < 0 && grant != 0) begin
        g = cyc;
        chk("grant", int'(grant), 1 << w);
        chk("sel", int'(sel), w);
      end
      if (fa_weights_load) begin loads++; load_c = cyc; end
      if (fa_start_comp) start_c = cyc;
      if ((done | err) != 0) begin end_c = cyc; end_v = done | err; end_err = |err; end
    end
    if (end_c < 0) chk("job_timeout", 0, 1);
    req[w] = 1'b0;
    es = g + (rl ? 1 : 0);
    ee = nr ? es + 1 + RM + TO : es + ((1 + RM > d) ? 1 + RM : d) + 1;
    chk("load_count", loads, rl ? 1 : 0);
    if (rl) chk("load_cycle", load_c, g);
    chk("start_cycle", start_c, es);
    chk("end_cycle", end_c, ee);
    chk("end_bit", int'(end_v), 1 << w);
    chk("end_is_err", int'(end_err), int'(nr));
    @(negedge clk);
    chk("post_grant", int'(grant), 0);
    chk("post_busy", int'(busy), 0);
    m_ptr = (w + 1) % N;
    if (rl) begin m_owner = w; m_valid = 1; end
    if (nr) m_valid = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_sel", int'(sel), 0);
    reset = 0;
    @(negedge clk);
    run_job(3'b001, 3'b000, 3, 0);
    run_job(3'b001, 3'b001, 3, 0);
    run_job(3'b010, 3'b010, 5, 0);
    run_job(3'b001, 3'b001, 1, 0);
    run_job(3'b001, 3'b000, 4, 1);
    run_job(3'b001, 3'b001, 3, 0);
    req = 3'b001; reuse_w = 3'b000; never = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("mid_no_pulse", int'(done | err), 0);
    end
    chk("mid_busy", int'(busy), 1);
    reset = 1; req = '0;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    reset = 0;
    m_ptr = 0; m_owner = 0; m_valid = 0;
    @(negedge clk);
    chk_idle_outputs("after_reset");
    run_job(3'b001, 3'b001, 3, 0);
    m_ptr = 0;
    reset = 1; @(negedge clk); reset = 0; @(negedge clk);
    for (int k = 0; k < 4; k++) run_job(3'b011, 3'b000, 2, 0);
    for (int k = 0; k < 40; k++)
      run_job(3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), $urandom_range(1, 8),
              $urandom_range(0, 7) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
